// File: rtl/ov_7670_pkg.sv
// rtl/ov_7670_pkg.sv - shared types and constants for the OV7670 stream emulator and capture
package ov_7670_pkg;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic [1:0] {
    PAT_BARS     = 2'd0,
    PAT_GRADIENT = 2'd1,
    PAT_WHITE    = 2'd2,
    PAT_COUNTER  = 2'd3
  } pattern_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } gen_state_e;

  // White, yellow, cyan, green, magenta, red, blue, black.
  localparam rgb565_t BAR_COLOURS [8] = '{
    rgb565_t'(16'hFFFF), rgb565_t'(16'hFFE0), rgb565_t'(16'h07FF), rgb565_t'(16'h07E0),
    rgb565_t'(16'hF81F), rgb565_t'(16'hF800), rgb565_t'(16'h001F), rgb565_t'(16'h0000)
  };

endpackage

// File: rtl/ov_7670_pattern.sv
// rtl/ov_7670_pattern.sv - combinational test-pattern pixel lookup (pattern, x, y) -> rgb565
module ov_7670_pattern
  import ov_7670_pkg::*;
#(
  parameter int H_ACTIVE = 640
) (
  input  pattern_e    pattern,
  input  logic [15:0] x,
  input  logic [15:0] y,
  output rgb565_t     pixel
);

  localparam logic [15:0] BAR_W    = 16'(H_ACTIVE / 8);
  localparam logic [15:0] LINE_PIX = 16'(H_ACTIVE);

  logic [2:0]  bar;
  logic [4:0]  diag;
  logic [15:0] index;

  always_comb begin
    bar   = 3'(x / BAR_W);
    diag  = 5'(x + y);
    // Counter pattern wraps naturally at 16 bits.
    index = y * LINE_PIX + x;
    pixel = '0;
    case (pattern)
      PAT_BARS:     pixel = BAR_COLOURS[bar];
      PAT_GRADIENT: pixel = '{r: x[4:0], g: y[5:0], b: diag};
      PAT_WHITE:    pixel = rgb565_t'(16'hFFFF);
      PAT_COUNTER:  pixel = rgb565_t'(index);
      default:      pixel = '0;
    endcase
  end

endmodule

// File: rtl/ov_7670_stream_gen.sv
// rtl/ov_7670_stream_gen.sv - OV7670 RGB565 camera output emulator driven by a pattern generator
module ov_7670_stream_gen
  import ov_7670_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10,
  parameter int PCLK_DIV    = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [1:0] pattern_sel,
  output logic       pclk,
  output logic       vsync,
  output logic       href,
  output logic [7:0] data,
  output logic       busy,
  output logic       frame_done
);

  localparam int LINE_LEN   = 2 * H_ACTIVE + H_BLANK;
  localparam int FRAME_ROWS = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT;
  localparam int COL_W      = $clog2(LINE_LEN + 1);
  localparam int ROW_W      = $clog2(FRAME_ROWS + 1);
  localparam int DIV_W      = $clog2(PCLK_DIV);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(LINE_LEN - 1);
  localparam logic [COL_W-1:0] HREF_END  = COL_W'(2 * H_ACTIVE);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(FRAME_ROWS - 1);
  localparam logic [ROW_W-1:0] VSYNC_END = ROW_W'(VSYNC_LINES);
  localparam logic [ROW_W-1:0] ACT_BEGIN = ROW_W'(VSYNC_LINES + V_BACK);
  localparam logic [ROW_W-1:0] ACT_END   = ROW_W'(VSYNC_LINES + V_BACK + V_ACTIVE);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(PCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(PCLK_DIV / 2);

  gen_state_e       state, state_nx;
  pattern_e         pattern_q, pattern_nx;
  logic [DIV_W-1:0] div, div_nx;
  logic [COL_W-1:0] col, col_nx;
  logic [ROW_W-1:0] row, row_nx;
  logic             tick, done_nx, vsync_nx, href_nx, run_nx;
  logic [7:0]       data_nx;
  logic [15:0]      pix_x, pix_y;
  rgb565_t          pixel;

  // A tick is the cycle whose closing edge wraps div to 0, i.e. the PCLK falling edge.
  assign tick   = (div == DIV_LAST);
  assign div_nx = tick ? '0 : div + 1'b1;

  always_comb begin
    state_nx   = state;
    pattern_nx = pattern_q;
    col_nx     = col;
    row_nx     = row;
    done_nx    = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nx   = RUN;
            pattern_nx = pattern_e'(pattern_sel);
            col_nx     = '0;
            row_nx     = '0;
          end
        end
        RUN: begin
          if (col == COL_LAST) begin
            col_nx = '0;
            if (row == ROW_LAST) begin
              row_nx  = '0;
              done_nx = 1'b1;
              if (start) pattern_nx = pattern_e'(pattern_sel);
              else       state_nx   = IDLE;
            end else begin
              row_nx = row + 1'b1;
            end
          end else begin
            col_nx = col + 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Outputs are derived from the post-tick counters so they land on the same edge.
  always_comb begin
    run_nx   = (state_nx == RUN);
    pix_x    = 16'(col_nx >> 1);
    pix_y    = 16'(row_nx - ACT_BEGIN);
    vsync_nx = run_nx && (row_nx < VSYNC_END);
    href_nx  = run_nx && (row_nx >= ACT_BEGIN) && (row_nx < ACT_END) && (col_nx < HREF_END);
    data_nx  = 8'h00;
    if (href_nx) data_nx = col_nx[0] ? pixel[7:0] : pixel[15:8];
  end

  ov_7670_pattern #(
    .H_ACTIVE (H_ACTIVE)
  ) u_pattern (
    .pattern (pattern_nx),
    .x       (pix_x),
    .y       (pix_y),
    .pixel   (pixel)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div        <= '0;
      state      <= IDLE;
      pattern_q  <= PAT_BARS;
      col        <= '0;
      row        <= '0;
      pclk       <= 1'b0;
      vsync      <= 1'b0;
      href       <= 1'b0;
      data       <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      div        <= div_nx;
      pclk       <= (div_nx >= DIV_HALF);
      frame_done <= done_nx;
      if (tick) begin
        state     <= state_nx;
        pattern_q <= pattern_nx;
        col       <= col_nx;
        row       <= row_nx;
        vsync     <= vsync_nx;
        href      <= href_nx;
        data      <= data_nx;
        busy      <= run_nx;
      end
    end
  end

endmodule

// File: tb/tb_ov_7670_stream_gen.sv
// tb/tb_ov_7670_stream_gen.sv - self-checking bench for the OV7670 stream emulator
module tb_ov_7670_stream_gen;

  localparam int H_ACTIVE    = 8;
  localparam int V_ACTIVE    = 4;
  localparam int H_BLANK     = 4;
  localparam int VSYNC_LINES = 1;
  localparam int V_BACK      = 1;
  localparam int V_FRONT     = 1;
  localparam int PCLK_DIV    = 2;
  localparam int LINE        = 2 * H_ACTIVE + H_BLANK;
  localparam int ROWS        = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT;
  localparam int FRAME_PCLKS = LINE * ROWS;
  localparam int FRAME_CLKS  = FRAME_PCLKS * PCLK_DIV;
  localparam int FIRST_ACT   = VSYNC_LINES + V_BACK;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] pattern_sel = 2'd0;
  logic       pclk, vsync, href, busy, frame_done;
  logic [7:0] data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [9:0] samp[$];
  int vs_idx[$];
  int vs_cyc[$];
  int done_cyc[$];

  ov_7670_stream_gen #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_BLANK(H_BLANK), .VSYNC_LINES(VSYNC_LINES),
    .V_BACK(V_BACK), .V_FRONT(V_FRONT), .PCLK_DIV(PCLK_DIV)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .pattern_sel(pattern_sel),
    .pclk(pclk), .vsync(vsync), .href(href), .data(data), .busy(busy), .frame_done(frame_done)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Reference pixel straight from the pattern definitions.
  function automatic logic [15:0] ref_pixel(input int pat, input int x, input int y);
    logic [15:0] v;
    v = 16'h0000;
    case (pat)
      0: case (x / (H_ACTIVE / 8))
           0: v = 16'hFFFF;  1: v = 16'hFFE0;  2: v = 16'h07FF;  3: v = 16'h07E0;
           4: v = 16'hF81F;  5: v = 16'hF800;  6: v = 16'h001F;  default: v = 16'h0000;
         endcase
      1: v = {5'(x % 32), 6'(y % 64), 5'((x + y) % 32)};
      2: v = 16'hFFFF;
      default: v = 16'((y * H_ACTIVE + x) % 65536);
    endcase
    return v;
  endfunction

  // Expected {vsync, href, data} at the k-th PCLK rise of a frame.
  function automatic logic [9:0] exp_triple(input int pat, input int k);
    int row, col;
    logic v, h;
    logic [15:0] p;
    logic [7:0] d;
    row = k / LINE;
    col = k % LINE;
    v = (row < VSYNC_LINES);
    h = (row >= FIRST_ACT) && (row < FIRST_ACT + V_ACTIVE) && (col < 2 * H_ACTIVE);
    p = ref_pixel(pat, col / 2, row - FIRST_ACT);
    d = h ? ((col % 2 == 1) ? p[7:0] : p[15:8]) : 8'h00;
    return {v, h, d};
  endfunction

  function automatic int frame_mismatches(input int base, input int pat, output int first_k);
    int n;
    n = 0;
    first_k = -1;
    for (int k = 0; k < FRAME_PCLKS; k++) begin
      if (base + k >= samp.size() || samp[base + k] !== exp_triple(pat, k)) begin
        if (n == 0) first_k = k;
        n++;
      end
    end
    return n;
  endfunction

  function automatic int tail_nonzero(input int from);
    int n;
    n = 0;
    for (int i = from; i < samp.size(); i++) if (samp[i] !== 10'd0) n++;
    return n;
  endfunction

  task automatic capture(input int n, input int drop_at, input int switch_at, input logic [1:0] switch_pat);
    logic pp, vp;
    samp.delete();
    vs_idx.delete();
    vs_cyc.delete();
    done_cyc.delete();
    pp = pclk;
    vp = vsync;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == drop_at) start = 1'b0;
      if (i == switch_at) pattern_sel = switch_pat;
      if (vsync && !vp) begin
        vs_idx.push_back(samp.size());
        vs_cyc.push_back(cyc);
      end
      if (pclk && !pp) samp.push_back({vsync, href, data});
      if (frame_done) done_cyc.push_back(cyc);
      pp = pclk;
      vp = vsync;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({pclk, vsync, href, data, busy, frame_done} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", {pclk, vsync, href, data, busy, frame_done});
    end
    reset_n = 1'b1;
  endtask

  task automatic test_idle();
    logic pp;
    int bad_out, bad_clk;
    bad_out = 0;
    bad_clk = 0;
    pp = pclk;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ({vsync, href, data, busy, frame_done} !== 12'd0) bad_out++;
      if (pclk === pp) bad_clk++;
      pp = pclk;
    end
    checks++;
    if (bad_out != 0) begin
      errors++;
      $display("FAIL idle_outputs: got %0d nonzero cycles required 0", bad_out);
    end
    checks++;
    if (bad_clk != 0) begin
      errors++;
      $display("FAIL idle_pclk_toggle: got %0d stuck cycles required 0", bad_clk);
    end
  endtask

  task automatic run_single(input string name, input int pat);
    int c0, base, fk, nm, tn;
    @(negedge clk);
    pattern_sel = 2'(pat);
    start = 1'b1;
    c0 = cyc;
    capture(400, 1, -1, 2'd0);
    checks++;
    if (vs_cyc.size() != 1 || vs_cyc[0] - c0 < 1 || vs_cyc[0] - c0 > PCLK_DIV) begin
      errors++;
      $display("FAIL %s_vsync_rise: got %0d rises, first at +%0d clk required 1 rise within %0d clk",
               name, vs_cyc.size(), (vs_cyc.size() > 0) ? vs_cyc[0] - c0 : -1, PCLK_DIV);
    end
    checks++;
    if (done_cyc.size() != 1 || vs_cyc.size() < 1 || done_cyc[0] - vs_cyc[0] != FRAME_CLKS) begin
      errors++;
      $display("FAIL %s_frame_done: got %0d pulses, delay %0d required 1 pulse at %0d clk", name,
               done_cyc.size(), (done_cyc.size() > 0 && vs_cyc.size() > 0) ? done_cyc[0] - vs_cyc[0] : -1,
               FRAME_CLKS);
    end
    base = (vs_idx.size() > 0) ? vs_idx[0] : 0;
    nm = frame_mismatches(base, pat, fk);
    checks++;
    if (nm != 0) begin
      errors++;
      $display("FAIL %s_stream: got %0d bad bytes (first k=%0d) required 0", name, nm, fk);
    end
    tn = tail_nonzero(base + FRAME_PCLKS);
    checks++;
    if (tn != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_after: got %0d active samples busy=%b required 0 and busy=0", name, tn, busy);
    end
  endtask

  task automatic test_single_frame();
    run_single("single_white", 2);
  endtask

  task automatic test_colour_bars();
    run_single("colour_bars", 0);
  endtask

  task automatic test_back_to_back();
    int fk, nm0, nm1, tn;
    @(negedge clk);
    pattern_sel = 2'd3;
    start = 1'b1;
    capture(700, 420, 140, 2'd2);
    checks++;
    if (vs_cyc.size() != 2 || done_cyc.size() != 2) begin
      errors++;
      $display("FAIL b2b_counts: got %0d vsync %0d done required 2 and 2", vs_cyc.size(), done_cyc.size());
    end else begin
      checks++;
      if (done_cyc[0] - vs_cyc[0] != FRAME_CLKS || done_cyc[1] - done_cyc[0] != FRAME_CLKS ||
          vs_cyc[1] != done_cyc[0]) begin
        errors++;
        $display("FAIL b2b_timing: got done gaps %0d,%0d vsync2-done1 %0d required %0d,%0d,0",
                 done_cyc[0] - vs_cyc[0], done_cyc[1] - done_cyc[0], vs_cyc[1] - done_cyc[0],
                 FRAME_CLKS, FRAME_CLKS);
      end
      nm0 = frame_mismatches(vs_idx[0], 3, fk);
      checks++;
      if (nm0 != 0) begin
        errors++;
        $display("FAIL b2b_counter_frame: got %0d bad bytes (first k=%0d) required 0", nm0, fk);
      end
      nm1 = frame_mismatches(vs_idx[1], 2, fk);
      checks++;
      if (nm1 != 0) begin
        errors++;
        $display("FAIL b2b_white_frame: got %0d bad bytes (first k=%0d) required 0", nm1, fk);
      end
      tn = tail_nonzero(vs_idx[1] + FRAME_PCLKS);
      checks++;
      if (tn != 0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL b2b_stop: got %0d active samples busy=%b required 0 and busy=0", tn, busy);
      end
    end
  endtask

  task automatic test_drop_start();
    int pat, drop, sw, fk, nm, tn;
    for (int it = 0; it < 3; it++) begin
      pat  = int'($urandom_range(0, 3));
      drop = int'($urandom_range(5, 270));
      sw   = int'($urandom_range(3, 270));
      @(negedge clk);
      pattern_sel = 2'(pat);
      start = 1'b1;
      capture(450, drop, sw, 2'($urandom_range(0, 3)));
      checks++;
      if (vs_cyc.size() != 1 || done_cyc.size() != 1 || done_cyc[0] - vs_cyc[0] != FRAME_CLKS) begin
        errors++;
        $display("FAIL drop_%0d_frames: got %0d vsync %0d done required 1 and 1 at %0d clk",
                 it, vs_cyc.size(), done_cyc.size(), FRAME_CLKS);
      end
      nm = frame_mismatches((vs_idx.size() > 0) ? vs_idx[0] : 0, pat, fk);
      checks++;
      if (nm != 0) begin
        errors++;
        $display("FAIL drop_%0d_stream pat=%0d drop=%0d: got %0d bad bytes (first k=%0d) required 0",
                 it, pat, drop, nm, fk);
      end
      tn = tail_nonzero(((vs_idx.size() > 0) ? vs_idx[0] : 0) + FRAME_PCLKS);
      checks++;
      if (tn != 0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL drop_%0d_idle: got %0d active samples busy=%b required 0 and busy=0", it, tn, busy);
      end
    end
  endtask

  task automatic test_async_reset();
    logic pp;
    logic found;
    int rises, c_rel, fk, nm;
    logic [9:0] exp;
    @(negedge clk);
    pattern_sel = 2'd1;
    start = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (vsync) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL areset_vsync_start: got no vsync required vsync within 10 clk");
    end
    rises = 0;
    pp = pclk;
    for (int i = 0; i < 400 && rises < 3 * LINE + 6; i++) begin
      @(negedge clk);
      if (pclk && !pp) rises++;
      pp = pclk;
    end
    exp = exp_triple(1, 3 * LINE + 5);
    checks++;
    if ({vsync, href, data} !== exp) begin
      errors++;
      $display("FAIL areset_pre_state: got %h required %h", {vsync, href, data}, exp);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({pclk, vsync, href, data, busy, frame_done} !== 13'd0) begin
      errors++;
      $display("FAIL areset_immediate: got %h required 0", {pclk, vsync, href, data, busy, frame_done});
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({pclk, vsync, href, data, busy, frame_done} !== 13'd0) begin
      errors++;
      $display("FAIL areset_held: got %h required 0", {pclk, vsync, href, data, busy, frame_done});
    end
    reset_n = 1'b1;
    c_rel = cyc;
    capture(400, 10, -1, 2'd0);
    checks++;
    if (vs_cyc.size() != 1 || vs_cyc[0] - c_rel != PCLK_DIV) begin
      errors++;
      $display("FAIL areset_restart: got %0d rises first at +%0d clk required 1 at +%0d", vs_cyc.size(),
               (vs_cyc.size() > 0) ? vs_cyc[0] - c_rel : -1, PCLK_DIV);
    end
    nm = frame_mismatches((vs_idx.size() > 0) ? vs_idx[0] : 0, 1, fk);
    checks++;
    if (nm != 0) begin
      errors++;
      $display("FAIL areset_frame: got %0d bad bytes (first k=%0d) required 0", nm, fk);
    end
    checks++;
    if (done_cyc.size() != 1 || vs_cyc.size() < 1 || done_cyc[0] - vs_cyc[0] != FRAME_CLKS || busy !== 1'b0) begin
      errors++;
      $display("FAIL areset_done: got %0d pulses busy=%b required 1 pulse at %0d clk and busy=0",
               done_cyc.size(), busy, FRAME_CLKS);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_frame();
    test_colour_bars();
    test_back_to_back();
    test_drop_start();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ov_7670_stream_gen.md
# ov_7670_stream_gen

Synthesizable OV7670 output emulator. It drives PCLK/VSYNC/HREF/D[7:0] in the camera's RGB565 byte stream format from an internal test-pattern generator. It is the transmit end of the camera pixel interface and feeds `ov_7670_capture` in loopback builds and benches, so capture can be exercised without a physical sensor. Everything runs from the system clock; PCLK is a divided, registered output.

## Interface
- `H_ACTIVE`, default 640: active pixels per line (2 bytes each); multiple of 8.
- `V_ACTIVE`, default 480: active lines per frame.
- `H_BLANK`, default 144: PCLK periods with HREF low after each line's active bytes.
- `VSYNC_LINES`, default 3: lines with VSYNC high at frame start.
- `V_BACK`, default 17: blank lines after VSYNC, before the first active line.
- `V_FRONT`, default 10: blank lines after the last active line.
- `PCLK_DIV`, default 2: clk cycles per PCLK period; even, ≥2.
- `clk` — in — 1 — system clock (CLOCK_50).
- `reset_n` — in — 1 — asynchronous, active-low reset.
- `start` — in — 1 — level; while high, frames are generated back-to-back.
- `pattern_sel` — in — 2 — 0 colour bars, 1 gradient, 2 solid white, 3 pixel counter; sampled at frame start only.
- `pclk` — out — 1 — emulated pixel clock.
- `vsync` — out — 1 — frame sync, active high.
- `href` — out — 1 — line valid, active high.
- `data` — out — 8 — pixel byte.
- `busy` — out — 1 — high while a frame is in progress.
- `frame_done` — out — 1 — one-clk pulse at the end of each frame.

## Operation
- Reset values: every output is 0 and the state is IDLE.
- Divider `div` counts 0..PCLK_DIV-1 continuously. `pclk` = (div ≥ PCLK_DIV/2), registered.
- A *tick* is the clk cycle where `div` wraps to 0, i.e. the PCLK falling edge. `vsync`, `href` and `data` change only on ticks. Capture samples them on the PCLK rising edge.
- States:
  - IDLE: outputs low except `pclk`. On a tick with `start`=1: latch `pattern_sel`, clear the counters, go to RUN, set `busy`.
  - RUN: `col` counts 0..2·H_ACTIVE+H_BLANK−1 per tick. `row` increments when `col` wraps and counts 0..VSYNC_LINES+V_BACK+V_ACTIVE+V_FRONT−1.
  - End of frame: on the tick where both counters wrap, pulse `frame_done` for one clk. If `start`=1, stay in RUN, relatch `pattern_sel` and begin the next frame. Otherwise go to IDLE and clear `busy`.
- Deasserting `start` mid-frame has no effect until the current frame completes. Frames are never truncated.
- `vsync` = row < VSYNC_LINES.
- `href` = row within the active region AND col < 2·H_ACTIVE.
- When `href`=0, `data` = 0x00.
- Pixel addressing: x = col>>1, y = active row index. Even col sends byte0 = {R5,G6[5:3]}; odd col sends byte1 = {G6[2:0],B5}.
- Patterns:
  - 0: 8 vertical bars of width H_ACTIVE/8, in order white, yellow, cyan, green, magenta, red, blue, black. Full-scale components: R5=1F, G6=3F, B5=1F.
  - 1: R5 = x[4:0], G6 = y[5:0], B5 = (x+y)[4:0], all truncating.
  - 2: every pixel 0xFFFF.
  - 3: 16-bit pixel index = y·H_ACTIVE+x, wrapping modulo 2^16 and restarting at 0 each frame.

## Timing
- Output latency: registered outputs reflect the counter state as of the previous tick.
- First frame: the first `vsync` rise occurs on the first tick after `start` is seen high.
- Line period: (2·H_ACTIVE+H_BLANK)·PCLK_DIV clk.
- Frame period: line period × (VSYNC_LINES+V_BACK+V_ACTIVE+V_FRONT).
- `frame_done` rises in the same clk as the tick that ends the frame.
- `reset_n` low mid-frame: all outputs go to 0 immediately (asynchronous). After release, the block restarts in IDLE with `div`=0.

## Structure
- Shared package `ov_7670_pkg`:
  - `rgb565_t` packed struct (r[4:0], g[5:0], b[4:0]).
  - `pattern_e` enum.
  - State enum `gen_state_e` {IDLE, RUN}.
  - Colour-bar constant array.
- Sub-module `ov_7670_pattern`: combinational function (pattern, x, y) → `rgb565_t`, shared with the capture checker.
- Top level holds the divider, the counters, the FSM and the output registers.

## Test plan
All scenarios use small parameters: H_ACTIVE=8, V_ACTIVE=4, H_BLANK=4, VSYNC_LINES=1, V_BACK=1, V_FRONT=1, PCLK_DIV=2. This gives a 20-PCLK line and a 7-line frame of 280 clk.

- Reset then idle: hold `start`=0 for 100 clk → `vsync`/`href`/`data`/`busy` stay 0 and `pclk` toggles every clk.
- Single frame: pulse `start` high for 1 tick, pattern 2 → exactly 4 HREF pulses of 16 PCLKs each, every byte 0xFF, one `frame_done` 280 clk after start, then IDLE.
- Colour bars: pattern 0 → per line, bytes are FF FF, FF E0, 07 FF, 07 E0, F8 1F, F8 00, 00 1F, 00 00.
- Continuous frames with a pattern switch mid-frame from 3 to 2: the current frame's counter bytes run 00 00, 00 01 … 00 1F; the next frame is all 0xFF; `frame_done` pulses every 280 clk.
- Drop `start` mid-frame: the frame completes fully, then `busy`=0 and there is no further VSYNC.
- Async reset asserted at row 3 / col 5: outputs are 0 in the same cycle; after release, a full frame restarts from VSYNC.
